// File: rtl/load_align_unit_if.sv
// Load request, memory read and response signal bundle for load_align_unit.
interface load_align_unit_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 32
);
   logic              req_valid;
   logic              req_ready;
   logic [ADDR_W-1:0] req_addr;
   logic [1:0]        req_size;
   logic              req_signed;
   logic              mem_rd;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_rdata;
   logic              rsp_valid;
   logic [DATA_W-1:0] rsp_data;
   logic              rsp_misalign;

   modport slave (
      input  req_valid, req_addr, req_size, req_signed, mem_rdata,
      output req_ready, mem_rd, mem_addr, rsp_valid, rsp_data, rsp_misalign
   );

   modport master (
      output req_valid, req_addr, req_size, req_signed, mem_rdata,
      input  req_ready, mem_rd, mem_addr, rsp_valid, rsp_data, rsp_misalign
   );
endinterface

// File: rtl/load_align_unit.sv
// Load unit: reads the containing word(s), extracts byte/half/word at the byte offset, extends.
// Build option UNALIGNED_SPLIT_EN: misaligned loads do two reads and merge them.
module load_align_unit #(
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned MEM_LAT = 1
) (
   input  logic             clk,
   input  logic             reset,
   load_align_unit_if.slave bus
);
   localparam int unsigned BYTES = DATA_W / 8;
   localparam int unsigned OFF_W = $clog2(BYTES);
   localparam int unsigned CNT_W = $clog2(MEM_LAT + 1);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RD0  = 2'd1;
`ifdef UNALIGNED_SPLIT_EN
   localparam logic [1:0] ST_RD1  = 2'd2;
`endif
   localparam logic [1:0] ST_RESP = 2'd3;

   logic [1:0]        state_q, state_nxt;
   logic [CNT_W-1:0]  cnt_q, cnt_nxt;
   logic [OFF_W-1:0]  off_q, off_nxt;
   logic [1:0]        size_q, size_nxt;
   logic              signed_q, signed_nxt;
   logic              req_ready_q, req_ready_nxt;
   logic              mem_rd_q, mem_rd_nxt;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_nxt;
   logic              rsp_valid_q, rsp_valid_nxt;
   logic [DATA_W-1:0] rsp_data_q, rsp_data_nxt;
   logic              rsp_misalign_q, rsp_misalign_nxt;
`ifdef UNALIGNED_SPLIT_EN
   logic [DATA_W-1:0] word0_q, word0_nxt;
`endif

   logic [DATA_W-1:0]   lo_word, hi_word, shifted, extracted;
   logic [2*DATA_W-1:0] merged;
   logic                sign_b, sign_h;
   logic [ADDR_W-1:0]   word_addr_c;

   // Half crossing the last byte, or any full word not on a word boundary.
   function automatic logic is_misaligned(input logic [OFF_W-1:0] off, input logic [1:0] size);
      return (size == 2'b01 && off == OFF_W'(BYTES - 1)) || (size == 2'b00 && off != '0);
   endfunction

   assign word_addr_c = {bus.req_addr[ADDR_W-1:OFF_W], OFF_W'(0)};

   // Merge {word1,word0}, shift by the byte offset, then size and extend.
   always_comb begin
      lo_word = bus.mem_rdata;
      hi_word = '0;
`ifdef UNALIGNED_SPLIT_EN
      if (state_q == ST_RD1) begin
         lo_word = word0_q;
         hi_word = bus.mem_rdata;
      end
`endif
      merged  = {hi_word, lo_word};
      shifted = DATA_W'(merged >> {off_q, 3'b000});
      sign_b  = signed_q & shifted[7];
      sign_h  = signed_q & shifted[15];
      if (size_q[1])
         extracted = {{(DATA_W-8){sign_b}}, shifted[7:0]};
      else if (size_q[0])
         extracted = {{(DATA_W-16){sign_h}}, shifted[15:0]};
      else
         extracted = shifted;
   end

   always_comb begin
      state_nxt        = state_q;
      cnt_nxt          = cnt_q;
      off_nxt          = off_q;
      size_nxt         = size_q;
      signed_nxt       = signed_q;
      mem_rd_nxt       = 1'b0;
      mem_addr_nxt     = mem_addr_q;
      rsp_valid_nxt    = 1'b0;
      rsp_data_nxt     = rsp_data_q;
      rsp_misalign_nxt = rsp_misalign_q;
`ifdef UNALIGNED_SPLIT_EN
      word0_nxt        = word0_q;
`endif

      case (state_q)
         ST_IDLE: begin
            if (bus.req_valid) begin
               off_nxt    = bus.req_addr[OFF_W-1:0];
               size_nxt   = bus.req_size;
               signed_nxt = bus.req_signed;
`ifndef UNALIGNED_SPLIT_EN
               if (is_misaligned(bus.req_addr[OFF_W-1:0], bus.req_size)) begin
                  // No split support: report immediately without touching memory.
                  state_nxt        = ST_RESP;
                  rsp_valid_nxt    = 1'b1;
                  rsp_data_nxt     = '0;
                  rsp_misalign_nxt = 1'b1;
               end else
`endif
               begin
                  state_nxt    = ST_RD0;
                  mem_rd_nxt   = 1'b1;
                  mem_addr_nxt = word_addr_c;
                  cnt_nxt      = '0;
               end
            end
         end

         ST_RD0: begin
            if (cnt_q == CNT_W'(MEM_LAT)) begin
`ifdef UNALIGNED_SPLIT_EN
               if (is_misaligned(off_q, size_q)) begin
                  word0_nxt    = bus.mem_rdata;
                  state_nxt    = ST_RD1;
                  mem_rd_nxt   = 1'b1;
                  mem_addr_nxt = mem_addr_q + ADDR_W'(BYTES);
                  cnt_nxt      = '0;
               end else
`endif
               begin
                  state_nxt        = ST_RESP;
                  rsp_valid_nxt    = 1'b1;
                  rsp_data_nxt     = extracted;
                  rsp_misalign_nxt = 1'b0;
               end
            end else begin
               cnt_nxt = cnt_q + CNT_W'(1);
            end
         end

`ifdef UNALIGNED_SPLIT_EN
         ST_RD1: begin
            if (cnt_q == CNT_W'(MEM_LAT)) begin
               state_nxt        = ST_RESP;
               rsp_valid_nxt    = 1'b1;
               rsp_data_nxt     = extracted;
               rsp_misalign_nxt = 1'b1;
            end else begin
               cnt_nxt = cnt_q + CNT_W'(1);
            end
         end
`endif

         ST_RESP: state_nxt = ST_IDLE;

         default: state_nxt = ST_IDLE;
      endcase

      req_ready_nxt = (state_nxt == ST_IDLE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q        <= ST_IDLE;
         cnt_q          <= '0;
         off_q          <= '0;
         size_q         <= '0;
         signed_q       <= 1'b0;
         req_ready_q    <= 1'b1;
         mem_rd_q       <= 1'b0;
         mem_addr_q     <= '0;
         rsp_valid_q    <= 1'b0;
         rsp_data_q     <= '0;
         rsp_misalign_q <= 1'b0;
`ifdef UNALIGNED_SPLIT_EN
         word0_q        <= '0;
`endif
      end else begin
         state_q        <= state_nxt;
         cnt_q          <= cnt_nxt;
         off_q          <= off_nxt;
         size_q         <= size_nxt;
         signed_q       <= signed_nxt;
         req_ready_q    <= req_ready_nxt;
         mem_rd_q       <= mem_rd_nxt;
         mem_addr_q     <= mem_addr_nxt;
         rsp_valid_q    <= rsp_valid_nxt;
         rsp_data_q     <= rsp_data_nxt;
         rsp_misalign_q <= rsp_misalign_nxt;
`ifdef UNALIGNED_SPLIT_EN
         word0_q        <= word0_nxt;
`endif
      end
   end

   assign bus.req_ready    = req_ready_q;
   assign bus.mem_rd       = mem_rd_q;
   assign bus.mem_addr     = mem_addr_q;
   assign bus.rsp_valid    = rsp_valid_q;
   assign bus.rsp_data     = rsp_data_q;
   assign bus.rsp_misalign = rsp_misalign_q;
endmodule

// File: tb/tb_load_align_unit.sv
// Scoreboard bench for load_align_unit (DATA_W=32, MEM_LAT=1) with a byte-level reference model.
module tb_load_align_unit;
   localparam int unsigned DW = 32;
   localparam int unsigned AW = 32;

   typedef struct {
      logic [31:0] data;
      logic        mis;
      int          lat;
      int          acc;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;

   exp_t        exp_q[$];
   logic [31:0] raddr_q[$];
   logic [31:0] held_exp = '0;
   int          prev_acc = -1;
   int          prev_lat = 0;
   logic        prev_hold = 1'b0;

   load_align_unit_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

   load_align_unit #(.DATA_W(DW), .ADDR_W(AW), .MEM_LAT(1)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] memword(input logic [31:0] wa);
      if (wa == 32'h100) return 32'h8899AABB;
      if (wa == 32'h104) return 32'h11223344;
      return (wa * 32'h9E3779B1) ^ 32'hC0FFEE11;
   endfunction

   function automatic logic [7:0] byte_at(input logic [31:0] a);
      logic [31:0] w;
      w = memword({a[31:2], 2'b00});
      return 8'(w >> (8 * int'(a[1:0])));
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Memory responder: data valid one cycle after the strobe, noise otherwise.
   always @(posedge clk) begin
      if (bus.mem_rd) bus.mem_rdata <= memword(bus.mem_addr);
      else            bus.mem_rdata <= $urandom();
   end

   // Monitor: response and read-address scoreboards.
   always @(negedge clk) begin
      exp_t e;
      logic [31:0] ea;
      if (reset) begin
         held_exp = '0;
      end else begin
         if (bus.rsp_valid) begin
            if (exp_q.size() == 0) begin
               check("unexpected_rsp", 64'(bus.rsp_valid), 64'(0));
            end else begin
               e = exp_q.pop_front();
               check("rsp_data", 64'(bus.rsp_data), 64'(e.data));
               check("rsp_misalign", 64'(bus.rsp_misalign), 64'(e.mis));
               check("rsp_latency", 64'(cyc - e.acc), 64'(e.lat));
               held_exp = e.data;
            end
         end else begin
            check("rsp_data_held", 64'(bus.rsp_data), 64'(held_exp));
         end
         if (bus.mem_rd) begin
            if (raddr_q.size() == 0) begin
               check("unexpected_mem_rd", 64'(bus.mem_rd), 64'(0));
            end else begin
               ea = raddr_q.pop_front();
               check("mem_addr", 64'(bus.mem_addr), 64'(ea));
            end
         end
      end
   end

   // Reference model: assemble bytes from byte addresses, decide split by range.
   task automatic model(input logic [31:0] a, input logic [1:0] sz, input logic sg, input int acc);
      exp_t        e;
      int          n;
      logic [31:0] val, base;
      logic        mis;
      n   = sz[1] ? 1 : (sz[0] ? 2 : 4);
      mis = (int'(a[1:0]) + n) > 4;
      val = '0;
      for (int i = 0; i < n; i++) val |= 32'(byte_at(a + 32'(i))) << (8 * i);
      if (sg && n < 4 && val[8*n-1]) val |= ~((32'h1 << (8 * n)) - 32'h1);
      base  = {a[31:2], 2'b00};
      e.acc = acc;
      e.mis = mis;
`ifdef UNALIGNED_SPLIT_EN
      e.data = val;
      e.lat  = mis ? 5 : 3;
      raddr_q.push_back(base);
      if (mis) raddr_q.push_back(base + 32'd4);
`else
      e.data = mis ? 32'h0 : val;
      e.lat  = mis ? 1 : 3;
      if (!mis) raddr_q.push_back(base);
`endif
      exp_q.push_back(e);
      prev_lat = e.lat;
   endtask

   // Present a request; returns at the negedge after the accepting edge.
   task automatic send(input logic [31:0] a, input logic [1:0] sz, input logic sg, input logic hold);
      int w;
      @(negedge clk);
      bus.req_valid  = 1'b1;
      bus.req_addr   = a;
      bus.req_size   = sz;
      bus.req_signed = sg;
      w = 0;
      while (!bus.req_ready && w < 60) begin
         @(negedge clk);
         w++;
      end
      if (!bus.req_ready) begin
         check("req_ready_timeout", 64'(bus.req_ready), 64'(1));
         bus.req_valid = 1'b0;
      end else begin
         if (prev_hold && prev_acc >= 0)
            check("accept_spacing", 64'(cyc - prev_acc), 64'(prev_lat + 1));
         prev_acc = cyc;
         model(a, sz, sg, cyc);
         @(negedge clk);
         check("req_ready_busy", 64'(bus.req_ready), 64'(0));
         if (!hold) bus.req_valid = 1'b0;
      end
      prev_hold = hold;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_req_ready"}, 64'(bus.req_ready), 64'(1));
      check({tag, "_mem_rd"}, 64'(bus.mem_rd), 64'(0));
      check({tag, "_mem_addr"}, 64'(bus.mem_addr), 64'(0));
      check({tag, "_rsp_valid"}, 64'(bus.rsp_valid), 64'(0));
      check({tag, "_rsp_data"}, 64'(bus.rsp_data), 64'(0));
      check({tag, "_rsp_misalign"}, 64'(bus.rsp_misalign), 64'(0));
   endtask

   task automatic drain();
      int w;
      w = 0;
      while ((exp_q.size() != 0 || raddr_q.size() != 0) && w < 60) begin
         @(negedge clk);
         w++;
      end
      check("drain_rsp_pending", 64'(exp_q.size()), 64'(0));
      check("drain_rd_pending", 64'(raddr_q.size()), 64'(0));
   endtask

   initial begin
      logic [31:0] a;
      bus.req_valid  = 1'b0;
      bus.req_addr   = '0;
      bus.req_size   = '0;
      bus.req_signed = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      reset = 1'b0;

      // Directed cases on the reference memory image.
      send(32'h103, 2'b10, 1'b1, 1'b0);
      send(32'h102, 2'b01, 1'b0, 1'b0);
      send(32'h101, 2'b01, 1'b1, 1'b0);
      send(32'h100, 2'b00, 1'b0, 1'b0);
      send(32'h103, 2'b01, 1'b0, 1'b0);
      send(32'h101, 2'b00, 1'b0, 1'b0);
      send(32'hFFFF_FFFD, 2'b00, 1'b1, 1'b0);
      send(32'h102, 2'b11, 1'b0, 1'b0);
      drain();

      // Reset two cycles into an access aborts it without a response.
      prev_hold = 1'b0;
`ifdef UNALIGNED_SPLIT_EN
      send(32'h103, 2'b01, 1'b0, 1'b0);
`else
      send(32'h100, 2'b00, 1'b0, 1'b0);
`endif
      @(negedge clk);
      reset = 1'b1;
      #1;
      check_reset_outputs("midreset");
      exp_q.delete();
      raddr_q.delete();
      repeat (2) @(negedge clk);
      check_reset_outputs("midreset_hold");
      reset = 1'b0;
      send(32'h104, 2'b00, 1'b0, 1'b0);
      drain();

      // Requester holds req_valid across back-to-back requests.
      prev_hold = 1'b0;
      send(32'h100, 2'b10, 1'b1, 1'b1);
      send(32'h103, 2'b01, 1'b1, 1'b1);
      send(32'h101, 2'b00, 1'b0, 1'b1);
      send(32'h104, 2'b01, 1'b1, 1'b0);
      drain();

      // Randomized mix of addresses, sizes, sign modes and issue spacing.
      prev_hold = 1'b0;
      for (int i = 0; i < 300; i++) begin
         a = ($urandom_range(0, 1) == 0) ? (32'h100 + 32'($urandom_range(0, 15))) : $urandom();
         send(a, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         if (!prev_hold) repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      bus.req_valid = 1'b0;
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
